uart_alu_resp_packer: RTL and testbench

//  Transmit-side packet builder for the UART ALU link. Accepts one ALU result
//  and its opcode, then serialises a response packet byte-by-byte onto the UART TX

---
 rtl/uart_alu_resp_packer_if.sv | 26 ++
 rtl/uart_alu_resp_packer.sv | 174 +++++++++++++++++
 tb/tb_uart_alu_resp_packer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_resp_packer_if.sv
// Handshake bundle for the UART ALU response packer.
//   Upstream (result side): valid_i, opcode_i, result_i in; ready_o out.
//   Downstream (UART TX side): data_o, valid_o out; ready_i in.
// The packer connects through the slave modport. The master modport serves the
// agent that plays both the ALU and the UART transmitter.
interface uart_alu_resp_packer_if #(
  parameter int unsigned RESULT_W = 64
);
  logic                valid_i;
  logic [7:0]          opcode_i;
  logic [RESULT_W-1:0] result_i;
  logic                ready_o;
  logic [7:0]          data_o;
  logic                valid_o;
  logic                ready_i;

  modport master (
    output valid_i, opcode_i, result_i, ready_i,
    input  ready_o, data_o, valid_o
  );

  modport slave (
    input  valid_i, opcode_i, result_i, ready_i,
    output ready_o, data_o, valid_o
  );
endinterface

// File: rtl/uart_alu_resp_packer.sv
// uart_alu_resp_packer: takes one ALU result and its opcode, then emits a
// response packet byte-by-byte to the UART TX stream:
//   opcode, 0x00, LEN[7:0], LEN[15:8], payload bytes LSB-first [, checksum]
// LEN counts every byte of the packet, including the header.
// Ports:
//   clk_i     clock, posedge
//   reset_ni  asynchronous active-low reset
//   bus       uart_alu_resp_packer_if.slave
//             valid_i/opcode_i/result_i/ready_o : result capture handshake
//             data_o/valid_o/ready_i            : TX byte handshake
// Optional feature: define UART_ALU_RESP_CHECKSUM_EN to append a trailing byte
// holding the XOR of all preceding packet bytes.
module uart_alu_resp_packer #(
  parameter int unsigned RESULT_W = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  uart_alu_resp_packer_if.slave  bus
);

  localparam int unsigned NBYTES = RESULT_W / 8;
`ifdef UART_ALU_RESP_CHECKSUM_EN
  localparam int unsigned CSUM_BYTES = 1;
`else
  localparam int unsigned CSUM_BYTES = 0;
`endif
  localparam int unsigned PKT_LEN  = 4 + NBYTES + CSUM_BYTES;
  localparam logic [15:0] LEN_W    = 16'(PKT_LEN);
  // Transfer index of the last payload byte.
  localparam logic [15:0] LAST_PAY = 16'(PKT_LEN - 1 - CSUM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_RSVD = 3'd2,
    S_LENL = 3'd3,
    S_LENM = 3'd4,
    S_PAY  = 3'd5,
    S_CSUM = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [RESULT_W-1:0] shift_q, shift_d;
  logic [RESULT_W-1:0] shift_nx;
  logic                xfer;
  logic                capture;
`ifdef UART_ALU_RESP_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  assign xfer     = valid_q & bus.ready_i;
  assign capture  = bus.valid_i & ready_q;
  assign shift_nx = shift_q >> 8;

  // State, output byte and payload registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= 16'h0000;
      shift_q <= '0;
`ifdef UART_ALU_RESP_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
`ifdef UART_ALU_RESP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next-state and next-output logic; each non-idle state advances on a transfer
  // and preloads the byte the following state presents.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
`ifdef UART_ALU_RESP_CHECKSUM_EN
    csum_d  = csum_q;
    if (xfer) csum_d = csum_q ^ data_q;
`endif
    if (xfer) cnt_d = cnt_q + 16'd1;

    unique case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (capture) begin
          state_d = S_HDR;
          data_d  = bus.opcode_i;
          valid_d = 1'b1;
          shift_d = bus.result_i;
          cnt_d   = 16'h0000;
`ifdef UART_ALU_RESP_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      S_HDR: begin
        if (xfer) begin
          state_d = S_RSVD;
          data_d  = 8'h00;
        end
      end
      S_RSVD: begin
        if (xfer) begin
          state_d = S_LENL;
          data_d  = LEN_W[7:0];
        end
      end
      S_LENL: begin
        if (xfer) begin
          state_d = S_LENM;
          data_d  = LEN_W[15:8];
        end
      end
      S_LENM: begin
        if (xfer) begin
          state_d = S_PAY;
          data_d  = shift_q[7:0];
        end
      end
      S_PAY: begin
        if (xfer) begin
          shift_d = shift_nx;
          if (cnt_q == LAST_PAY) begin
`ifdef UART_ALU_RESP_CHECKSUM_EN
            state_d = S_CSUM;
            data_d  = csum_q ^ data_q;
`else
            state_d = S_IDLE;
            valid_d = 1'b0;
`endif
          end else begin
            data_d = shift_nx[7:0];
          end
        end
      end
`ifdef UART_ALU_RESP_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // ready_o is a registered copy of (state == Idle).
    ready_d = (state_d == S_IDLE);
  end

  assign bus.ready_o = ready_q;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_uart_alu_resp_packer.sv
// Scoreboard bench for uart_alu_resp_packer (RESULT_W=64). Stimulus pushes the
// expected TX bytes into a queue; an independent monitor pops and compares on
// every byte transfer. Define UART_ALU_RESP_CHECKSUM_EN for the checksum build.
module tb_uart_alu_resp_packer;
  localparam int unsigned RESULT_W = 64;
`ifdef UART_ALU_RESP_CHECKSUM_EN
  localparam bit         CSUM   = 1'b1;
  localparam int         LEN    = 13;
  localparam logic [7:0] LEN_LO = 8'h0d;
`else
  localparam bit         CSUM   = 1'b0;
  localparam int         LEN    = 12;
  localparam logic [7:0] LEN_LO = 8'h0c;
`endif

  logic clk_i = 1'b0;
  logic reset_ni;
  always #5 clk_i = ~clk_i;

  uart_alu_resp_packer_if #(.RESULT_W(RESULT_W)) bus ();

  uart_alu_resp_packer #(.RESULT_W(RESULT_W)) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .bus     (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference packet model: header, LSB-first payload, optional XOR trailer.
  task automatic push_pkt(input logic [7:0] op, input logic [63:0] res);
    logic [7:0] b[$];
    logic [7:0] x;
    b.push_back(op);
    b.push_back(8'h00);
    b.push_back(LEN_LO);
    b.push_back(8'h00);
    for (int i = 0; i < 8; i++) b.push_back(res[8*i +: 8]);
    x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    if (CSUM) b.push_back(x);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  task automatic drive(input logic [7:0] op, input logic [63:0] res);
    bus.valid_i  = 1'b1;
    bus.opcode_i = op;
    bus.result_i = res;
  endtask

  // Hold valid_i until the packer is ready, then drop it after the capture edge.
  task automatic wait_capture();
    int n = 0;
    forever begin
      @(negedge clk_i);
      if (bus.ready_o === 1'b1) break;
      n++;
      if (n > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL capture_timeout: ready_o=%b after %0d cycles, required 1", bus.ready_o, n);
        bus.valid_i = 1'b0;
        return;
      end
    end
    @(posedge clk_i);
    #1 bus.valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && bus.ready_o === 1'b1 && bus.valid_o === 1'b0) break;
      n++;
      if (n > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL idle_timeout: %0d bytes outstanding, ready_o=%b, required 0 bytes and ready_o=1",
                 exp_q.size(), bus.ready_o);
        return;
      end
    end
  endtask

  // Monitor: every byte transfer must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (reset_ni === 1'b1 && bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_byte: got unexpected 0x%0h, required no transfer", bus.data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_byte", 64'(bus.data_o), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1[13];
    logic [7:0] t4[12];
    logic [7:0] x;

    // Reset with valid_i asserted: must be ignored.
    reset_ni     = 1'b0;
    bus.ready_i  = 1'b1;
    drive(8'hff, 64'hffff_ffff_ffff_ffff);
    repeat (3) @(negedge clk_i);
    check("rst_valid_o", 64'(bus.valid_o), 64'd0);
    check("rst_data_o", 64'(bus.data_o), 64'h00);
    check("rst_ready_o", 64'(bus.ready_o), 64'd1);
    bus.valid_i = 1'b0;
    reset_ni    = 1'b1;
    repeat (2) @(negedge clk_i);
    check("post_rst_valid_o", 64'(bus.valid_o), 64'd0);

    // Test 1: basic packet, ready_o returns on cycle LEN+1.
    t1 = '{8'had, 8'h00, LEN_LO, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, 8'ha7};
    for (int i = 0; i < LEN; i++) exp_q.push_back(t1[i]);
    @(posedge clk_i);
    #1 drive(8'had, 64'h7);
    wait_capture();
    repeat (LEN - 1) @(posedge clk_i);
    @(negedge clk_i);
    check("t1_ready_busy", 64'(bus.ready_o), 64'd0);
    @(negedge clk_i);
    check("t1_ready_done", 64'(bus.ready_o), 64'd1);
    check("t1_valid_done", 64'(bus.valid_o), 64'd0);
    check("t1_all_sent", 64'(exp_q.size()), 64'd0);

    // Test 2: backpressure while LEN low byte is presented.
    push_pkt(8'had, 64'h7);
    @(posedge clk_i);
    #1 drive(8'had, 64'h7);
    wait_capture();
    @(posedge clk_i);
    @(posedge clk_i);
    #1 bus.ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("t2_hold_data", 64'(bus.data_o), 64'(LEN_LO));
      check("t2_hold_valid", 64'(bus.valid_o), 64'd1);
      @(posedge clk_i);
    end
    #1 bus.ready_i = 1'b1;
    wait_idle();

    // Test 3: second result offered during payload waits for the packet to end.
    push_pkt(8'h5b, 64'h1234_5678);
    @(posedge clk_i);
    #1 drive(8'h5b, 64'h1234_5678);
    wait_capture();
    repeat (5) @(posedge clk_i);
    #1 drive(8'h5b, 64'h55);
    push_pkt(8'h5b, 64'h55);
    repeat (3) begin
      @(negedge clk_i);
      check("t3_busy_ready", 64'(bus.ready_o), 64'd0);
    end
    wait_capture();
    wait_idle();

    // Test 5: reset after the sixth transfer aborts the packet.
    push_pkt(8'had, 64'h7);
    @(posedge clk_i);
    #1 drive(8'had, 64'h7);
    wait_capture();
    repeat (6) @(posedge clk_i);
    #2 reset_ni = 1'b0;
    #1 check("t5_abort_valid", 64'(bus.valid_o), 64'd0);
    check("t5_sent_before_abort", 64'(exp_q.size()), 64'(LEN - 6));
    exp_q.delete();
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    check("t5_ready_after", 64'(bus.ready_o), 64'd1);
    check("t5_valid_after", 64'(bus.valid_o), 64'd0);

    // Test 4: byte order, also the first packet after the reset abort.
    t4 = '{8'h63, 8'h00, LEN_LO, 8'h00, 8'hef, 8'hcd, 8'hab, 8'h89,
           8'h67, 8'h45, 8'h23, 8'h01};
    x = 8'h00;
    foreach (t4[i]) begin
      exp_q.push_back(t4[i]);
      x = x ^ t4[i];
    end
    if (CSUM) exp_q.push_back(x);
    @(posedge clk_i);
    #1 drive(8'h63, 64'h0123_4567_89ab_cdef);
    wait_capture();
    wait_idle();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
